cl_frame_tx: RTL and testbench



---
 rtl/cl_frame_tx_pkg.sv | 31 +++
 rtl/cl_frame_tx_if.sv | 32 +++
 rtl/cl_pixel_packer.sv | 30 +++
 rtl/cl_frame_tx.sv | 223 ++++++++++++++++++++++
 tb/tb_cl_frame_tx.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cl_frame_tx_pkg.sv
// Shared constants and types for the Camera Link 10-tap test-pattern transmitter.
package cl_frame_tx_pkg;

    localparam int   N_FRAME_SIZE     = 20;
    localparam logic TRUE             = 1'b1;
    localparam logic FALSE            = 1'b0;

    localparam int   PIXEL_BITS       = 12;
    localparam int   PIX_PER_GROUP    = 10;
    localparam int   CLOCKS_PER_GROUP = 3;
    localparam int   TAP_BITS         = 40;
    localparam int   GROUP_BITS       = PIX_PER_GROUP * PIXEL_BITS;

    typedef enum logic [1:0] {
        CL_0 = 2'd0,
        CL_1 = 2'd1,
        CL_2 = 2'd2
    } cl_phase_e;

    typedef logic [PIXEL_BITS-1:0]          pixel_t;
    typedef pixel_t [PIX_PER_GROUP-1:0]     pixel_group_t;

    // Width needed to hold values 0..value-1; never narrower than one bit.
    function automatic int log2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/cl_frame_tx_if.sv
// Control/status handshake plus the Camera Link video bus of the frame transmitter.
interface cl_frame_tx_if;
    import cl_frame_tx_pkg::*;

    logic                    start;
    logic [N_FRAME_SIZE-1:0] n_frame;
    logic                    stop;
    logic                    busy;
    logic                    frame_done;
    logic [N_FRAME_SIZE-1:0] frame_cnt;
    logic                    cl_fval;
    logic                    cl_lval;
    logic [7:0]              cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e;
    logic [7:0]              cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j;

    // The transmitter side.
    modport master (
        input  start, n_frame, stop,
        output busy, frame_done, frame_cnt, cl_fval, cl_lval,
        output cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
        output cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
    );

    // The controller / capture side.
    modport slave (
        output start, n_frame, stop,
        input  busy, frame_done, frame_cnt, cl_fval, cl_lval,
        input  cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e,
        input  cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j
    );

endinterface

// File: rtl/cl_pixel_packer.sv
// Selects the 40-bit tap slice of a 10-pixel group for one of the three CL clock phases.
module cl_pixel_packer
    import cl_frame_tx_pkg::*;
(
    input  pixel_group_t          pix,
    input  cl_phase_e             phase,
    output logic [TAP_BITS-1:0]   slice
);

    logic [GROUP_BITS-1:0] word;

    // Pixel 0 occupies the most significant bits of the group word.
    always_comb begin
        word = '0;
        for (int k = 0; k < PIX_PER_GROUP; k++) begin
            word[(PIX_PER_GROUP-1-k)*PIXEL_BITS +: PIXEL_BITS] = pix[k];
        end
    end

    // NOTE: every path assigns slice (default arm included), so no latch is inferred.
    always_comb begin
        case (phase)
            CL_0:    slice = word[3*TAP_BITS-1:2*TAP_BITS];
            CL_1:    slice = word[2*TAP_BITS-1:TAP_BITS];
            CL_2:    slice = word[TAP_BITS-1:0];
            default: slice = '0;
        endcase
    end

endmodule

// File: rtl/cl_frame_tx.sv
// Camera Link 10-tap frame transmitter: FVAL/LVAL timing plus a moving 12-bit ramp pattern.
module cl_frame_tx
    import cl_frame_tx_pkg::*;
#(
    parameter int PIXEL_SIZE = 12,
    parameter int N_COL      = 2560,
    parameter int N_ROW      = 1080,
    parameter int H_BLANK    = 16,
    parameter int V_BLANK    = 64,
    parameter int FV_LEAD    = 2,
    parameter int FV_TRAIL   = 2
) (
    input  logic          clk_85,
    input  logic          reset,
    cl_frame_tx_if.master cl
);

    localparam int N_GRP  = N_COL / PIX_PER_GROUP;
    localparam int GRP_W  = log2(N_GRP);
    localparam int ROW_W  = log2(N_ROW);
    localparam int T_M1   = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int T_M2   = (FV_LEAD > FV_TRAIL) ? FV_LEAD : FV_TRAIL;
    localparam int T_MAX  = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int TMR_W  = log2(T_MAX);

    localparam logic [TMR_W-1:0]      T_LEAD   = TMR_W'(FV_LEAD - 1);
    localparam logic [TMR_W-1:0]      T_HBLANK = TMR_W'(H_BLANK - 1);
    localparam logic [TMR_W-1:0]      T_TRAIL  = TMR_W'(FV_TRAIL - 1);
    localparam logic [TMR_W-1:0]      T_VBLANK = TMR_W'(V_BLANK - 1);
    localparam logic [GRP_W-1:0]      LAST_GRP = GRP_W'(N_GRP - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(N_ROW - 1);
    localparam logic [PIXEL_SIZE-1:0] BTM_FLIP = PIXEL_SIZE'(1) << (PIXEL_SIZE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD   = 3'd1;
    localparam logic [2:0] S_LINE   = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_TRAIL  = 3'd4;
    localparam logic [2:0] S_VBLANK = 3'd5;

    logic [2:0]              state_q,     state_d;
    logic [TMR_W-1:0]        timer_q,     timer_d;
    logic [GRP_W-1:0]        group_q,     group_d;
    cl_phase_e               phase_q,     phase_d;
    logic [ROW_W-1:0]        row_q,       row_d;
    logic [N_FRAME_SIZE-1:0] frame_cnt_q, frame_cnt_d;
    logic [N_FRAME_SIZE-1:0] n_frame_q,   n_frame_d;
    logic                    stop_q,      stop_d;
    logic                    done_d;
    logic                    fval_q, lval_q, busy_q, done_q;
    logic [TAP_BITS-1:0]     top_q, btm_q;

    logic                    timer_zero, last_grp, last_row, frames_done;
    logic                    fval_d, lval_d;
    pixel_group_t            pix_top, pix_btm;
    logic [TAP_BITS-1:0]     slice_top, slice_btm;

    assign timer_zero  = (timer_q == '0);
    assign last_grp    = (group_q == LAST_GRP);
    assign last_row    = (row_q == LAST_ROW);
    assign frames_done = stop_q || ((n_frame_q != '0) && (frame_cnt_q == n_frame_q));

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        group_d     = group_q;
        phase_d     = phase_q;
        row_d       = row_q;
        frame_cnt_d = frame_cnt_q;
        n_frame_d   = n_frame_q;
        stop_d      = stop_q;
        done_d      = FALSE;

        case (state_q)
            S_IDLE: begin
                if (cl.start) begin
                    state_d     = S_LEAD;
                    timer_d     = T_LEAD;
                    group_d     = '0;
                    phase_d     = CL_0;
                    row_d       = '0;
                    frame_cnt_d = '0;
                    n_frame_d   = cl.n_frame;
                    stop_d      = cl.stop;
                end
            end
            S_LEAD: begin
                if (timer_zero) state_d = S_LINE;
                else            timer_d = timer_q - 1'b1;
            end
            S_LINE: begin
                if (phase_q == CL_0) begin
                    phase_d = CL_1;
                end else if (phase_q == CL_1) begin
                    phase_d = CL_2;
                end else begin
                    phase_d = CL_0;
                    if (!last_grp) begin
                        group_d = group_q + 1'b1;
                    end else begin
                        group_d = '0;
                        if (last_row) begin
                            row_d   = '0;
                            state_d = S_TRAIL;
                            timer_d = T_TRAIL;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = S_HBLANK;
                            timer_d = T_HBLANK;
                        end
                    end
                end
            end
            S_HBLANK: begin
                if (timer_zero) state_d = S_LINE;
                else            timer_d = timer_q - 1'b1;
            end
            S_TRAIL: begin
                if (timer_zero) begin
                    state_d     = S_VBLANK;
                    timer_d     = T_VBLANK;
                    frame_cnt_d = frame_cnt_q + 1'b1;
                    done_d      = TRUE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_VBLANK: begin
                if (!timer_zero) begin
                    timer_d = timer_q - 1'b1;
                end else if (frames_done) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_LEAD;
                    timer_d = T_LEAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A stop is only remembered once a run is under way; it takes effect at frame end.
        if ((state_q != S_IDLE) && cl.stop) stop_d = TRUE;
    end

    assign lval_d = (state_d == S_LINE);
    assign fval_d = (state_d == S_LEAD) || (state_d == S_LINE) ||
                    (state_d == S_HBLANK) || (state_d == S_TRAIL);

    // Pixels are built from next-cycle counters so the registered ports line up with LVAL.
    always_comb begin
        pix_top = '0;
        pix_btm = '0;
        for (int k = 0; k < PIX_PER_GROUP; k++) begin
            pix_top[k] = PIXEL_SIZE'(PIX_PER_GROUP * int'(group_d) + k +
                                     int'(row_d) + int'(frame_cnt_q));
            pix_btm[k] = pix_top[k] ^ BTM_FLIP;
        end
    end

    cl_pixel_packer u_pack_top (
        .pix   (pix_top),
        .phase (phase_d),
        .slice (slice_top)
    );

    cl_pixel_packer u_pack_btm (
        .pix   (pix_btm),
        .phase (phase_d),
        .slice (slice_btm)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_85 or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= '0;
            group_q     <= '0;
            phase_q     <= CL_0;
            row_q       <= '0;
            frame_cnt_q <= '0;
            n_frame_q   <= '0;
            stop_q      <= FALSE;
            fval_q      <= FALSE;
            lval_q      <= FALSE;
            busy_q      <= FALSE;
            done_q      <= FALSE;
            top_q       <= '0;
            btm_q       <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            group_q     <= group_d;
            phase_q     <= phase_d;
            row_q       <= row_d;
            frame_cnt_q <= frame_cnt_d;
            n_frame_q   <= n_frame_d;
            stop_q      <= stop_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
            busy_q      <= (state_d != S_IDLE);
            done_q      <= done_d;
            top_q       <= lval_d ? slice_top : '0;
            btm_q       <= lval_d ? slice_btm : '0;
        end
    end

    assign cl.busy       = busy_q;
    assign cl.frame_done = done_q;
    assign cl.frame_cnt  = frame_cnt_q;
    assign cl.cl_fval    = fval_q;
    assign cl.cl_lval    = lval_q;
    assign cl.cl_port_a  = top_q[39:32];
    assign cl.cl_port_b  = top_q[31:24];
    assign cl.cl_port_c  = top_q[23:16];
    assign cl.cl_port_d  = top_q[15:8];
    assign cl.cl_port_e  = top_q[7:0];
    assign cl.cl_port_f  = btm_q[39:32];
    assign cl.cl_port_g  = btm_q[31:24];
    assign cl.cl_port_h  = btm_q[23:16];
    assign cl.cl_port_i  = btm_q[15:8];
    assign cl.cl_port_j  = btm_q[7:0];

endmodule

// File: tb/tb_cl_frame_tx.sv
// Scoreboard bench for cl_frame_tx: frame-level reference model feeds queues, a monitor drains them.
module tb_cl_frame_tx;
    import cl_frame_tx_pkg::*;

    localparam int N_COL     = 20;
    localparam int N_ROW     = 2;
    localparam int H_BLANK   = 4;
    localparam int V_BLANK   = 8;
    localparam int FV_LEAD   = 2;
    localparam int FV_TRAIL  = 2;
    localparam int N_GRP     = N_COL / 10;
    localparam int LINE_CLKS = 3 * N_GRP;
    localparam int FVAL_CLKS = FV_LEAD + N_ROW * LINE_CLKS + (N_ROW - 1) * H_BLANK + FV_TRAIL;
    localparam int PERIOD    = FVAL_CLKS + V_BLANK;

    typedef struct {
        logic [1:0] pair;   // {fval, lval}
        int         len;    // 0 = any length
    } seg_t;

    logic [79:0] beat_q[$];
    logic [19:0] done_q[$];
    seg_t        seg_q[$];

    int   tests;
    int   fails;
    logic mon_en;
    logic clk_85;
    logic reset;

    cl_frame_tx_if cl ();

    cl_frame_tx #(
        .PIXEL_SIZE (12),
        .N_COL      (N_COL),
        .N_ROW      (N_ROW),
        .H_BLANK    (H_BLANK),
        .V_BLANK    (V_BLANK),
        .FV_LEAD    (FV_LEAD),
        .FV_TRAIL   (FV_TRAIL)
    ) dut (
        .clk_85 (clk_85),
        .reset  (reset),
        .cl     (cl)
    );

    initial clk_85 = 1'b0;
    always #5 clk_85 = ~clk_85;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_missing(input string name);
        tests++;
        fails++;
        $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
    endtask

    function automatic logic [79:0] ports();
        return {cl.cl_port_a, cl.cl_port_b, cl.cl_port_c, cl.cl_port_d, cl.cl_port_e,
                cl.cl_port_f, cl.cl_port_g, cl.cl_port_h, cl.cl_port_i, cl.cl_port_j};
    endfunction

    task automatic push_seg(input logic [1:0] pair, input int len);
        seg_t s;
        s.pair = pair;
        s.len  = len;
        seg_q.push_back(s);
    endtask

    // Reference: whole frames as segment lengths, pixel beats and frame_done counts.
    task automatic push_frames(input int total);
        logic [119:0] wt, wb;
        logic [11:0]  p;
        push_seg(2'b00, 0);
        for (int f = 0; f < total; f++) begin
            push_seg(2'b10, FV_LEAD);
            for (int r = 0; r < N_ROW; r++) begin
                push_seg(2'b11, LINE_CLKS);
                for (int g = 0; g < N_GRP; g++) begin
                    wt = '0;
                    wb = '0;
                    for (int k = 0; k < 10; k++) begin
                        p  = 12'((10 * g + k + r + f) % 4096);
                        wt = {wt[107:0], p};
                        wb = {wb[107:0], p ^ 12'h800};
                    end
                    for (int ph = 0; ph < 3; ph++)
                        beat_q.push_back({wt[119-40*ph -: 40], wb[119-40*ph -: 40]});
                end
                if (r < N_ROW - 1) push_seg(2'b10, H_BLANK);
            end
            push_seg(2'b10, FV_TRAIL);
            done_q.push_back(20'(f + 1));
            if (f < total - 1) push_seg(2'b00, V_BLANK);
        end
    endtask

    // Frames sent for n_frame n with a stop sampled t clocks after the start edge.
    function automatic int frames_for(input int n, input int t_stop);
        int sf;
        if (t_stop < 0)       sf = 1 << 30;
        else if (t_stop == 0) sf = 1;
        else                  sf = (t_stop - 1) / PERIOD + 1;
        if (n == 0) return sf;
        return (n < sf) ? n : sf;
    endfunction

    task automatic mid_reset();
        mon_en   = 1'b0;
        reset    = 1'b1;
        cl.start = 1'b0;
        cl.stop  = 1'b0;
        #1;
        check("rst_mid_fval",  cl.cl_fval, 0);
        check("rst_mid_lval",  cl.cl_lval, 0);
        check("rst_mid_ports", ports(), 0);
        check("rst_mid_busy",  cl.busy, 0);
        check("rst_mid_cnt",   cl.frame_cnt, 0);
        beat_q.delete();
        done_q.delete();
        seg_q.delete();
        repeat (2) @(negedge clk_85);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
    endtask

    // t_stop/t_busy/t_reset: clock index after the start edge, or -1 for none.
    task automatic run(input int n, input int t_stop, input int t_busy, input int t_reset);
        int total;
        total = frames_for(n, t_stop);
        push_frames(total);
        for (int k = 0; k <= total * PERIOD + 2; k++) begin
            @(negedge clk_85);
            #1;
            if (k == t_reset) begin
                check("lval_before_reset", cl.cl_lval, 1);
                mid_reset();
                return;
            end
            cl.start   = (k == 0) || (k == t_busy);
            cl.stop    = (k == t_stop);
            cl.n_frame = (k == 0) ? 20'(n) : 20'($urandom);
        end
        check("busy_end",      cl.busy, 0);
        check("frame_cnt_end", cl.frame_cnt, 20'(total));
        check("beats_drained", beat_q.size(), 0);
        check("done_drained",  done_q.size(), 0);
        check("segs_drained",  seg_q.size(), 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a beat, a segment end or frame_done.
    initial begin : monitor
        logic [1:0]  cur_pair, pair, prev_fval_pair;
        int          cur_len, since_done;
        logic        prev_busy, prev_fval;
        logic [79:0] exp_beat;
        seg_t        s;
        cur_pair   = 2'b00;
        cur_len    = 0;
        since_done = 0;
        prev_busy  = 1'b0;
        prev_fval  = 1'b0;
        forever begin
            @(negedge clk_85);
            if (!mon_en) begin
                cur_pair   = 2'b00;
                cur_len    = 0;
                since_done = 0;
                prev_busy  = 1'b0;
                prev_fval  = 1'b0;
            end else begin
                pair = {cl.cl_fval, cl.cl_lval};
                if (pair == cur_pair) begin
                    cur_len++;
                end else begin
                    if (seg_q.size() == 0) begin
                        report_missing("seg_extra");
                    end else begin
                        s = seg_q.pop_front();
                        check("seg_kind", cur_pair, s.pair);
                        if (s.len != 0) check("seg_len", cur_len, s.len);
                    end
                    cur_pair = pair;
                    cur_len  = 1;
                end

                if (cl.cl_lval) begin
                    if (beat_q.size() == 0) begin
                        report_missing("beat_extra");
                    end else begin
                        exp_beat = beat_q.pop_front();
                        check("beat_data", ports(), exp_beat);
                    end
                end else begin
                    check("ports_idle", ports(), 0);
                end

                if (cl.frame_done) begin
                    since_done     = 0;
                    prev_fval_pair = {prev_fval, cl.cl_fval};
                    check("done_on_fval_fall", prev_fval_pair, 2'b10);
                    if (done_q.size() == 0) report_missing("done_extra");
                    else                    check("frame_cnt", cl.frame_cnt, done_q.pop_front());
                end else begin
                    since_done++;
                end

                if (prev_busy && !cl.busy) check("busy_fall_after_vblank", since_done, V_BLANK);
                prev_busy = cl.busy;
                prev_fval = cl.cl_fval;
            end
        end
    end

    initial begin : stimulus
        int n, t_stop, t_busy, total;
        tests      = 0;
        fails      = 0;
        mon_en     = 1'b0;
        reset      = 1'b1;
        cl.start   = 1'b0;
        cl.stop    = 1'b0;
        cl.n_frame = '0;
        repeat (3) @(negedge clk_85);
        #1;
        check("rst_fval",  cl.cl_fval, 0);
        check("rst_lval",  cl.cl_lval, 0);
        check("rst_busy",  cl.busy, 0);
        check("rst_done",  cl.frame_done, 0);
        check("rst_cnt",   cl.frame_cnt, 0);
        check("rst_ports", ports(), 0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk_85);

        run(1, -1, -1, -1);                          // single frame, nominal timing
        run(3, 0, 5, -1);                            // start+stop together, start while busy
        run(0, 2 * PERIOD + FV_LEAD + 3, -1, -1);    // free-run, stop mid-line of frame 2
        run(1, -1, -1, FV_LEAD + 3);                 // reset in the middle of a line

        @(negedge clk_85);
        #1;
        cl.stop = 1'b1;                              // stop while idle is ignored
        @(negedge clk_85);
        #1;
        cl.stop = 1'b0;
        run(2, -1, -1, -1);

        for (int i = 0; i < 10; i++) begin
            n = $urandom_range(0, 3);
            if (n == 0 || $urandom_range(0, 1) == 1) t_stop = $urandom_range(0, 3 * PERIOD);
            else                                     t_stop = -1;
            total  = frames_for(n, t_stop);
            t_busy = ($urandom_range(0, 1) == 1) ? $urandom_range(1, total * PERIOD) : -1;
            repeat ($urandom_range(0, 4)) @(negedge clk_85);
            run(n, t_stop, t_busy, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
